// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants and the squeeze FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keccak_pkg;

  localparam int LANE_W              = 64;
  localparam int STATE_W             = 1600;
  localparam int NUM_LANES           = 25;
  localparam int SHAKE128_RATE_LANES = 21;
  localparam int SHAKE256_RATE_LANES = 17;

  // Wide enough to index any lane of the 25-lane state.
  localparam int LANE_IDX_W          = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PERM = 2'd1,
    STREAM    = 2'd2,
    REQ       = 2'd3
  } sq_state_e;

endpackage

// File: rtl/shake_rate_buf.sv
// Capture register for the rate lanes of the Keccak state, with a lane-select read mux.
// Latency: load takes effect on the next clk edge; the read mux is combinational from registered contents.
// Backpressure: none; contents hold until the next load.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (contents cleared)
//   load       capture lanes 0..RATE_LANES-1 of state_in this cycle
//   state_in   full 1600-bit core state; lane i = state_in[64*i +: 64]
//   lane_sel   lane index to present on lane_dat
//   lane_dat   selected captured lane (zero when lane_sel is out of range)
module shake_rate_buf
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = SHAKE128_RATE_LANES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [STATE_W-1:0]    state_in,
  input  logic [LANE_IDX_W-1:0] lane_sel,
  output logic [LANE_W-1:0]     lane_dat
);

  logic [LANE_W-1:0] rate_q [RATE_LANES];
  logic [LANE_W-1:0] rate_d [RATE_LANES];

  always_comb begin
    for (int i = 0; i < RATE_LANES; i++) begin
      rate_d[i] = load ? state_in[LANE_W*i +: LANE_W] : rate_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RATE_LANES; i++) begin
        rate_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RATE_LANES; i++) begin
        rate_q[i] <= rate_d[i];
      end
    end
  end

  // Compare-based mux so a non-power-of-two lane count never indexes past the array.
  always_comb begin
    lane_dat = '0;
    for (int i = 0; i < RATE_LANES; i++) begin
      if (lane_sel == LANE_IDX_W'(i)) begin
        lane_dat = rate_q[i];
      end
    end
  end

  // Capacity lanes are deliberately never captured.
  if (RATE_LANES < NUM_LANES) begin : g_capacity
    logic unused_capacity;
    assign unused_capacity = ^state_in[STATE_W-1:LANE_W*RATE_LANES];
  end

endmodule

// File: rtl/shake_squeezer.sv
// SHAKE squeeze reader: captures the rate lanes after each permutation and streams them as 64-bit lanes.
// Latency: perm_valid at t gives lane 0 at t+1; last-lane handshake at u gives perm_req at u+1.
// Backpressure: out_data/out_last hold while out_valid & !out_ready; next permutation only requested after the last lane.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, stop            open a session from IDLE / abort to IDLE (stop wins)
//   perm_state, perm_valid core state and its completion strobe (sampled only in WAIT_PERM)
//   perm_req               one-cycle request for the next permutation
//   out_data/valid/ready   lane stream; out_last marks lane RATE_LANES-1
//   blk_cnt                blocks fully delivered this session (wraps)
//   busy                   session active (any state but IDLE)
module shake_squeezer
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = SHAKE128_RATE_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [STATE_W-1:0] perm_state,
  input  logic               perm_valid,
  output logic               perm_req,
  output logic [LANE_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [7:0]         blk_cnt,
  output logic               busy
);

  sq_state_e             state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_idx_q, lane_idx_d;
  logic [7:0]            blk_cnt_q, blk_cnt_d;

  logic                  last_lane;
  logic                  hs;
  logic                  load;
  logic [LANE_W-1:0]     lane_dat;

  assign last_lane = (lane_idx_q == LANE_IDX_W'(RATE_LANES - 1));
  assign hs        = (state_q == STREAM) && out_ready;
  assign load      = (state_q == WAIT_PERM) && perm_valid && !stop;

  shake_rate_buf #(
    .RATE_LANES (RATE_LANES)
  ) u_rate_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .state_in (perm_state),
    .lane_sel (lane_idx_q),
    .lane_dat (lane_dat)
  );

  // State register together with the lane and block counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  // Next state; stop overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start)            state_d = WAIT_PERM;
      WAIT_PERM: if (perm_valid)       state_d = STREAM;
      STREAM:    if (hs && last_lane)  state_d = REQ;
      REQ:                             state_d = WAIT_PERM;
      default:                         state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
    end
  end

  // Counters. A lane accepted alongside stop is consumed, but never completes a block.
  always_comb begin
    lane_idx_d = lane_idx_q;
    blk_cnt_d  = blk_cnt_q;
    if (stop) begin
      lane_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE:      if (start)      blk_cnt_d  = '0;
        WAIT_PERM: if (perm_valid) lane_idx_d = '0;
        STREAM: begin
          if (hs) begin
            if (last_lane) blk_cnt_d  = blk_cnt_q + 8'd1;
            else           lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    perm_req  = (state_q == REQ);
    out_valid = (state_q == STREAM);
    out_last  = (state_q == STREAM) && last_lane;
    out_data  = (state_q == STREAM) ? lane_dat : '0;
    busy      = (state_q != IDLE);
    blk_cnt   = blk_cnt_q;
  end

endmodule
